data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/data_mem_responder.sv | 204 ++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM pipeline stage and the data memory
// responder. The master side is the pipeline; the slave side is the responder.
`timescale 1ns/1ps
interface data_mem_responder_if;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [1:0]  ReqSize;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        RespValid;
  logic [31:0] ReadData;
  logic        AddrError;
  logic        Stall;

  modport master (
    output ReqValid, ReqWrite, ReqSize, Address, WriteData,
    input  ReqReady, RespValid, ReadData, AddrError, Stall
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqSize, Address, WriteData,
    output ReqReady, RespValid, ReadData, AddrError, Stall
  );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder. A request is accepted in IDLE, held
// for LATENCY clock edges, and completed with a one-cycle RespValid pulse.
// Stores commit and loads are sampled on the edge that enters RESP, so a
// reset while waiting discards the request without touching storage.
`timescale 1ns/1ps
module data_mem_responder #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 128
) (
  input logic                  Clk,
  input logic                  Reset,
  data_mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(LATENCY - 1);

  state_t      state_r, state_s;
  logic [2:0]  cnt_r, cnt_s;
  logic        write_r;
  logic [1:0]  size_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] rdata_r;
  logic        aerr_r;
  logic [31:0] mem_r [0:DEPTH-1];

  logic        in_idle_s;
  logic        accept_s;
  logic        go_resp_s;
  logic        cur_write_s;
  logic [1:0]  cur_size_s;
  logic [31:0] cur_addr_s;
  logic [31:0] cur_wdata_s;
  logic [6:0]  idx_s;
  logic        err_s;
  logic        we_s;
  logic [31:0] rd_word_s;

  // Misaligned, out-of-range or reserved-size access.
  function automatic logic addr_err(input logic [31:0] a, input logic [1:0] sz);
    logic bad;
    bad = (a[31:9] != 23'd0) || ({25'd0, a[8:2]} >= 32'(DEPTH));
    case (sz)
      2'b00:   bad = bad || (a[1:0] != 2'b00);
      2'b01:   bad = bad || a[0];
      2'b10:   bad = bad;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Zero-extended load lane extraction.
  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz);
    logic [31:0] v;
    case (sz)
      2'b00:   v = w;
      2'b01:   v = a[1] ? {16'd0, w[31:16]} : {16'd0, w[15:0]};
      2'b10: begin
        case (a[1:0])
          2'b00:   v = {24'd0, w[7:0]};
          2'b01:   v = {24'd0, w[15:8]};
          2'b10:   v = {24'd0, w[23:16]};
          default: v = {24'd0, w[31:24]};
        endcase
      end
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  // Merge store data into the old word; untouched lanes keep their value.
  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] v;
    v = w;
    case (sz)
      2'b00:   v = d;
      2'b01: begin
        if (a[1]) v[31:16] = d[15:0];
        else      v[15:0]  = d[15:0];
      end
      2'b10: begin
        case (a[1:0])
          2'b00:   v[7:0]   = d[7:0];
          2'b01:   v[15:8]  = d[7:0];
          2'b10:   v[23:16] = d[7:0];
          default: v[31:24] = d[7:0];
        endcase
      end
      default: v = w;
    endcase
    return v;
  endfunction

  // In IDLE the live inputs describe the request (needed when LATENCY=1);
  // afterwards only the latched copy is used.
  assign in_idle_s   = (state_r == IDLE);
  assign accept_s    = in_idle_s && bus.ReqValid;
  assign cur_write_s = in_idle_s ? bus.ReqWrite  : write_r;
  assign cur_size_s  = in_idle_s ? bus.ReqSize   : size_r;
  assign cur_addr_s  = in_idle_s ? bus.Address   : addr_r;
  assign cur_wdata_s = in_idle_s ? bus.WriteData : wdata_r;
  assign idx_s       = cur_addr_s[8:2];
  assign err_s       = addr_err(cur_addr_s, cur_size_s);
  assign go_resp_s   = (accept_s && (LATENCY == 1)) ||
                       ((state_r == WAIT) && (cnt_r == 3'd1));
  assign rd_word_s   = mem_r[idx_s];
  assign we_s        = go_resp_s && cur_write_s && !err_s && Reset;

  assign bus.ReqReady  = in_idle_s;
  assign bus.RespValid = (state_r == RESP);
  assign bus.Stall     = accept_s || (state_r == WAIT);
  assign bus.ReadData  = rdata_r;
  assign bus.AddrError = aerr_r;

  // State and latency counter register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r <= IDLE;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          cnt_s   = LAT_M1;
          state_s = (LATENCY == 1) ? RESP : WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        cnt_s = cnt_r - 3'd1;
        if (cnt_r == 3'd1) state_s = RESP;
        else               state_s = WAIT;
      end
      RESP: begin
        state_s = IDLE;
        cnt_s   = 3'd0;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 3'd0;
      end
    endcase
  end

  // Capture the request on acceptance; later input changes are ignored.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      write_r <= 1'b0;
      size_r  <= 2'b00;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
    end else if (accept_s) begin
      write_r <= bus.ReqWrite;
      size_r  <= bus.ReqSize;
      addr_r  <= bus.Address;
      wdata_r <= bus.WriteData;
    end else begin
      write_r <= write_r;
      size_r  <= size_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
    end
  end

  // Response data/error registers: loaded entering RESP, zero otherwise.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rdata_r <= 32'd0;
      aerr_r  <= 1'b0;
    end else if (go_resp_s) begin
      aerr_r  <= err_s;
      rdata_r <= (err_s || cur_write_s) ? 32'd0 : load_val(rd_word_s, cur_addr_s, cur_size_s);
    end else begin
      rdata_r <= 32'd0;
      aerr_r  <= 1'b0;
    end
  end

  // Storage array; deliberately not reset so contents survive Reset.
  always_ff @(posedge Clk) begin
    if (we_s) begin
      mem_r[idx_s] <= store_merge(rd_word_s, cur_wdata_s, cur_addr_s, cur_size_s);
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: a LATENCY=2 responder driven with directed and random
// requests against a byte-addressed memory model, plus LATENCY=1 and
// LATENCY=7 instances exercised with ReqValid held high.
`timescale 1ns/1ps
module tb_data_mem_responder;
  localparam int LAT = 2;

  logic Clk;
  logic Reset;

  data_mem_responder_if m ();
  data_mem_responder_if if1 ();
  data_mem_responder_if if7 ();

  data_mem_responder #(.LATENCY(LAT), .DEPTH(128)) u2 (.Clk(Clk), .Reset(Reset), .bus(m));
  data_mem_responder #(.LATENCY(1),   .DEPTH(128)) u1 (.Clk(Clk), .Reset(Reset), .bus(if1));
  data_mem_responder #(.LATENCY(7),   .DEPTH(128)) u7 (.Clk(Clk), .Reset(Reset), .bus(if7));

  // Shared stimulus for the back-to-back instances, routed by sel.
  logic [1:0]  sel;
  logic        b_valid;
  logic [31:0] b_addr;
  logic        b_ready, b_resp, b_stall, b_aerr;
  logic [31:0] b_rdata;

  assign if1.ReqValid  = b_valid && (sel == 2'd1);
  assign if1.ReqWrite  = 1'b0;
  assign if1.ReqSize   = 2'b00;
  assign if1.Address   = b_addr;
  assign if1.WriteData = 32'd0;
  assign if7.ReqValid  = b_valid && (sel == 2'd2);
  assign if7.ReqWrite  = 1'b0;
  assign if7.ReqSize   = 2'b00;
  assign if7.Address   = b_addr;
  assign if7.WriteData = 32'd0;
  assign b_ready = (sel == 2'd1) ? if1.ReqReady  : if7.ReqReady;
  assign b_resp  = (sel == 2'd1) ? if1.RespValid : if7.RespValid;
  assign b_stall = (sel == 2'd1) ? if1.Stall     : if7.Stall;
  assign b_aerr  = (sel == 2'd1) ? if1.AddrError : if7.AddrError;
  assign b_rdata = (sel == 2'd1) ? if1.ReadData  : if7.ReadData;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] model_mem [0:127];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed little-endian memory of 512 bytes.
  task automatic model_access(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                              input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int unsigned a, sh, nbytes;
    logic [31:0] mask, w;
    a      = addr;
    nbytes = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
    err    = (sz == 2'd3) || (a >= 512) || ((a % nbytes) != 0);
    rd     = 32'd0;
    if (!err) begin
      w    = model_mem[a / 4];
      sh   = (a % 4) * 8;
      mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (nbytes * 8)) - 32'd1);
      if (wr) model_mem[a / 4] = (w & ~(mask << sh)) | ((wd & mask) << sh);
      else    rd = (w >> sh) & mask;
    end
  endtask

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          k;
    model_access(wr, sz, addr, wd, exp_rd, exp_err);
    @(negedge Clk);
    m.ReqValid  = 1'b1;
    m.ReqWrite  = wr;
    m.ReqSize   = sz;
    m.Address   = addr;
    m.WriteData = wd;
    #1;
    chk("req_ready", 32'(m.ReqReady), 32'd1);
    chk("stall_accept", 32'(m.Stall), 32'd1);
    @(posedge Clk);
    #1;
    m.ReqValid  = 1'b0;
    m.ReqWrite  = 1'($urandom_range(0, 1));
    m.ReqSize   = 2'($urandom_range(0, 3));
    m.Address   = $urandom;
    m.WriteData = $urandom;
    for (k = 1; k <= 20; k++) begin
      @(negedge Clk);
      if (m.RespValid === 1'b1) break;
      chk("stall_wait", 32'(m.Stall), 32'd1);
    end
    chk("latency", 32'(k), 32'(LAT));
    chk("stall_resp", 32'(m.Stall), 32'd0);
    chk("read_data", m.ReadData, exp_rd);
    chk("addr_error", 32'(m.AddrError), 32'(exp_err));
    @(negedge Clk);
    chk("resp_pulse", 32'(m.RespValid), 32'd0);
    chk("read_data_idle", m.ReadData, 32'd0);
  endtask

  // ReqValid held high: accept every lat+1 cycles, one response per accept.
  task automatic b2b(input logic [1:0] s, input int lat);
    int acc, rsp, p;
    sel = s;
    acc = 0;
    rsp = 0;
    @(negedge Clk);
    b_valid = 1'b1;
    for (int c = 0; c < 6 * (lat + 1); c++) begin
      if (c > 0) @(negedge Clk);
      b_addr = 32'($urandom_range(0, 127)) << 2;
      #1;
      p = c % (lat + 1);
      chk("b2b_ready", 32'(b_ready), 32'(p == 0));
      chk("b2b_resp", 32'(b_resp), 32'(p == lat));
      chk("b2b_stall", 32'(b_stall), 32'(p != lat));
      chk("b2b_aerr", 32'(b_aerr), 32'd0);
      if (p != lat) chk("b2b_rdata_idle", b_rdata, 32'd0);
      if (b_ready && b_valid) acc++;
      if (b_resp) rsp++;
    end
    b_valid = 1'b0;
    chk("b2b_accepts", 32'(acc), 32'd6);
    chk("b2b_resps", 32'(rsp), 32'd6);
    repeat (3) @(negedge Clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] prior;
    Reset       = 1'b0;
    m.ReqValid  = 1'b0;
    m.ReqWrite  = 1'b0;
    m.ReqSize   = 2'b00;
    m.Address   = 32'd0;
    m.WriteData = 32'd0;
    sel         = 2'd0;
    b_valid     = 1'b0;
    b_addr      = 32'd0;
    for (int i = 0; i < 128; i++) model_mem[i] = 32'd0;

    repeat (3) @(negedge Clk);
    chk("rst_resp_valid", 32'(m.RespValid), 32'd0);
    chk("rst_read_data", m.ReadData, 32'd0);
    chk("rst_addr_error", 32'(m.AddrError), 32'd0);
    Reset = 1'b1;
    #1;
    chk("rst_req_ready", 32'(m.ReqReady), 32'd1);
    chk("rst_stall", 32'(m.Stall), 32'd0);

    // Give every word a known value so no check relies on power-up contents.
    for (int i = 0; i < 128; i++) do_req(1'b1, 2'b00, 32'(i * 4), $urandom);

    // Word store/load round trip.
    do_req(1'b1, 2'b00, 32'h10, 32'hDEAD_BEEF);
    do_req(1'b0, 2'b00, 32'h10, 32'd0);
    // Byte store over zero.
    do_req(1'b1, 2'b00, 32'h10, 32'd0);
    do_req(1'b1, 2'b10, 32'h13, 32'hFFFF_FFAB);
    do_req(1'b0, 2'b00, 32'h10, 32'd0);
    do_req(1'b0, 2'b10, 32'h13, 32'd0);
    // Half store over all-ones.
    do_req(1'b1, 2'b00, 32'h20, 32'hFFFF_FFFF);
    do_req(1'b1, 2'b01, 32'h22, 32'h5555_1234);
    do_req(1'b0, 2'b01, 32'h22, 32'd0);
    do_req(1'b0, 2'b00, 32'h20, 32'd0);
    // Error cases, then confirm storage untouched.
    do_req(1'b0, 2'b00, 32'h11, 32'd0);
    do_req(1'b0, 2'b01, 32'h21, 32'd0);
    do_req(1'b0, 2'b10, 32'h200, 32'd0);
    do_req(1'b1, 2'b00, 32'h200, 32'h1111_1111);
    do_req(1'b1, 2'b00, 32'h11, 32'h2222_2222);
    do_req(1'b1, 2'b11, 32'h10, 32'h3333_3333);
    do_req(1'b0, 2'b00, 32'h10, 32'd0);
    do_req(1'b0, 2'b00, 32'h20, 32'd0);

    // Reset during WAIT discards a pending store.
    do_req(1'b1, 2'b00, 32'h30, 32'hCAFE_0030);
    prior = model_mem[12];
    @(negedge Clk);
    m.ReqValid  = 1'b1;
    m.ReqWrite  = 1'b1;
    m.ReqSize   = 2'b00;
    m.Address   = 32'h30;
    m.WriteData = 32'h55;
    @(posedge Clk);
    #1;
    m.ReqValid = 1'b0;
    @(negedge Clk);
    chk("pre_rst_stall", 32'(m.Stall), 32'd1);
    #1;
    Reset = 1'b0;
    #1;
    chk("midrst_resp_valid", 32'(m.RespValid), 32'd0);
    chk("midrst_read_data", m.ReadData, 32'd0);
    chk("midrst_addr_error", 32'(m.AddrError), 32'd0);
    chk("midrst_stall", 32'(m.Stall), 32'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("post_rst_ready", 32'(m.ReqReady), 32'd1);
    chk("model_prior", model_mem[12], prior);
    do_req(1'b0, 2'b00, 32'h30, 32'd0);

    // Random traffic, mostly in range.
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 511));
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom);
    end
    for (int i = 0; i < 128; i++) do_req(1'b0, 2'b00, 32'(i * 4), 32'd0);

    // Back-to-back throughput at the latency extremes.
    b2b(2'd1, 1);
    b2b(2'd2, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
